// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout
// Raster-order read engine on framebuffer port B. A frameStart pulse (taken
// only while idle) streams one IMG_W x IMG_H frame to the downstream stage over
// a valid/ready interface. A 2-entry output buffer absorbs the framebuffer's
// 1-cycle read latency, so backpressure never drops or repeats a pixel.
//
// Optional build macro: SCANOUT_VFLIP_EN. When it is defined, rows are read
// bottom row first. Columns and the positions of the stream tags are unchanged.
//
// Ports:
//   clk          single clock, also the framebuffer clkB
//   resetN       asynchronous active-low reset
//   frameStart   one-cycle start pulse, ignored while busy
//   busy         frame in progress (after accepted start until last handshake)
//   fbAddress    framebuffer addressB
//   fbData       framebuffer dataOutB, valid the cycle after the address
//   pixelData    head pixel value
//   pixelValid   head entry valid
//   pixelReady   downstream accept
//   pixelLineEnd head pixel is the last column of a row
//   pixelLast    head pixel is the last pixel of the frame
module framebuffer_scanout #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2048,
  parameter int IMG_W = 64,
  parameter int IMG_H = 32
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     frameStart,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] fbAddress,
  input  logic [WIDTH-1:0]         fbData,
  output logic [WIDTH-1:0]         pixelData,
  output logic                     pixelValid,
  input  logic                     pixelReady,
  output logic                     pixelLineEnd,
  output logic                     pixelLast
);

  // state | meaning
  // IDLE  | waiting for frameStart, no reads
  // ISSUE | issuing reads in raster order whenever a buffer slot is free
  // DRAIN | all reads issued, waiting for the buffer to empty

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
  localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 1);
  localparam logic [AW-1:0] ROW_PITCH = AW'(IMG_W);

  if (IMG_W * IMG_H > DEPTH) begin : g_size_check
    $error("framebuffer_scanout: IMG_W*IMG_H exceeds DEPTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]    row, col;
  logic [AW-1:0]    row_term;
  logic [AW-1:0]    addr_cur;
  logic [AW-1:0]    addr_last;
  logic             col_end, row_end;
  logic             start, issue, last_issue;
  logic             pop, room;
  logic [1:0]       committed;

  logic             read_pending;
  logic             pend_line_end, pend_last;

  logic [WIDTH-1:0] buf_data [2];
  logic             buf_line_end [2];
  logic             buf_last [2];
  logic             head, tail;
  logic [1:0]       count;

  assign col_end    = (col == COL_LAST);
  assign row_end    = (row == ROW_LAST);
  assign last_issue = issue && col_end && row_end;
  assign pop        = pixelValid && pixelReady;

  // Slots already spoken for: entries that stay after this cycle's pop plus
  // the read still in flight. Counting the pop lets a steady stream issue one
  // read per cycle. The total never exceeds 2, so the buffer cannot overflow.
  assign committed = count + {1'b0, read_pending} - {1'b0, pop};
  assign room      = (committed < 2'd2);

`ifdef SCANOUT_VFLIP_EN
  assign row_term = ROW_LAST - row;
`else
  assign row_term = row;
`endif

  assign addr_cur = row_term * ROW_PITCH + col;

  // The address is combinational during an issue cycle. Between issues it
  // holds the last issued address.
  assign fbAddress = issue ? addr_cur : addr_last;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (frameStart) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Leave on the edge that accepts the final pixel so busy drops with it.
        if (!read_pending && ((count == 2'd0) || ((count == 2'd1) && pop)))
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy  = 1'b0;
    start = 1'b0;
    issue = 1'b0;
    case (state)
      S_IDLE: begin
        start = frameStart;
      end
      S_ISSUE: begin
        busy  = 1'b1;
        issue = room;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------- raster counters ----------------
  // After the final read, the counters stay put. They are cleared again by
  // the next start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      row <= '0;
      col <= '0;
    end else if (start) begin
      row <= '0;
      col <= '0;
    end else if (issue && !last_issue) begin
      if (col_end) begin
        col <= '0;
        row <= row + AW'(1);
      end else begin
        col <= col + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addr_last <= '0;
    end else if (issue) begin
      addr_last <= addr_cur;
    end
  end

  // ---------------- read return tracking ----------------
  // The stream tags are computed at issue time and travel with the read.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      read_pending  <= 1'b0;
      pend_line_end <= 1'b0;
      pend_last     <= 1'b0;
    end else begin
      read_pending  <= issue;
      pend_line_end <= issue && col_end;
      pend_last     <= last_issue;
    end
  end

  // ---------------- 2-entry output buffer ----------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i]     <= '0;
        buf_line_end[i] <= 1'b0;
        buf_last[i]     <= 1'b0;
      end
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (read_pending) begin
        buf_data[tail]     <= fbData;
        buf_line_end[tail] <= pend_line_end;
        buf_last[tail]     <= pend_last;
        tail               <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      count <= committed;
    end
  end

  assign pixelValid   = (count != 2'd0);
  assign pixelData    = buf_data[head];
  assign pixelLineEnd = buf_line_end[head];
  assign pixelLast    = buf_last[head];

endmodule

// File: tb/tb_framebuffer_scanout.sv
module tb_framebuffer_scanout;
  localparam int WIDTH = 9;
  localparam int DEPTH = 2048;
  localparam int IMG_W = 64;
  localparam int IMG_H = 32;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int LIMIT = 20000;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic             frameStart = 1'b0;
  logic             pixelReady = 1'b0;
  logic             busy, pixelValid, pixelLineEnd, pixelLast;
  logic [AW-1:0]    fbAddress;
  logic [WIDTH-1:0] fbData = '0;
  logic [WIDTH-1:0] pixelData;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Framebuffer port B model: memory[a] = a[8:0], one-cycle synchronous read.
  always @(posedge clk) fbData <= fbAddress[WIDTH-1:0];

  framebuffer_scanout #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk(clk), .resetN(resetN), .frameStart(frameStart), .busy(busy),
    .fbAddress(fbAddress), .fbData(fbData), .pixelData(pixelData),
    .pixelValid(pixelValid), .pixelReady(pixelReady),
    .pixelLineEnd(pixelLineEnd), .pixelLast(pixelLast)
  );

  function automatic logic [31:0] exp_addr(input int i);
    logic [31:0] r, c;
    r = i / IMG_W;
    c = i % IMG_W;
`ifdef SCANOUT_VFLIP_EN
    r = IMG_H - 1 - r;
`endif
    exp_addr = r * IMG_W + c;
  endfunction

  // {last, lineEnd, data} expected at stream index i
  function automatic logic [WIDTH+1:0] exp_pix(input int i);
    logic [31:0] a;
    a = exp_addr(i);
    exp_pix = {(i == NPIX - 1), ((i % IMG_W) == IMG_W - 1), a[WIDTH-1:0]};
  endfunction

  // Inverse of exp_addr: stream position of a framebuffer address.
  function automatic int addr_pos(input logic [AW-1:0] a);
    int r, c;
    r = int'(a) / IMG_W;
    c = int'(a) % IMG_W;
`ifdef SCANOUT_VFLIP_EN
    r = IMG_H - 1 - r;
`endif
    addr_pos = r * IMG_W + c;
  endfunction

  // Drives one start pulse; returns at the negedge after the sampling edge.
  task automatic pulse_start();
    @(negedge clk);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    resetN = 1'b0;
    frameStart = 1'b0;
    pixelReady = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
    n_checks++; if (pixelValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b expected 0", pixelValid); end
    n_checks++; if (pixelData !== '0) begin n_fail++; $display("FAIL reset_data got %0h expected 0", pixelData); end
    n_checks++; if (pixelLineEnd !== 1'b0) begin n_fail++; $display("FAIL reset_lineend got %b expected 0", pixelLineEnd); end
    n_checks++; if (pixelLast !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b expected 0", pixelLast); end
    n_checks++; if (fbAddress !== '0) begin n_fail++; $display("FAIL reset_addr got %0h expected 0", fbAddress); end
    @(negedge clk);
    resetN = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (pixelValid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL reset_idle got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_full_frame();
    int idx, cyc, first;
    pixelReady = 1'b1;
    pulse_start();
    cyc = 1; first = -1; idx = 0;
    while (idx < NPIX && cyc < LIMIT) begin
      #1;
      if (pixelValid && first < 0) first = cyc;
      if (pixelValid && pixelReady) begin
        n_checks++;
        if ({pixelLast, pixelLineEnd, pixelData} !== exp_pix(idx)) begin
          n_fail++;
          $display("FAIL full_pixel idx %0d got %0h expected %0h", idx, {pixelLast, pixelLineEnd, pixelData}, exp_pix(idx));
        end
        if (idx == NPIX - 1) begin
          n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_last got %b expected 1", busy); end
        end
        idx++;
      end
      if (idx < NPIX) begin @(negedge clk); cyc++; end
    end
    n_checks++; if (idx !== NPIX) begin n_fail++; $display("FAIL full_count got %0d expected %0d", idx, NPIX); end
    n_checks++; if (first !== 3) begin n_fail++; $display("FAIL full_latency got %0d expected 3", first); end
    n_checks++; if (cyc !== 3 + NPIX - 1) begin n_fail++; $display("FAIL full_throughput got %0d expected %0d", cyc, 3 + NPIX - 1); end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_drop got %b expected 0", busy); end
    n_checks++; if (pixelValid !== 1'b0) begin n_fail++; $display("FAIL full_valid_drop got %b expected 0", pixelValid); end
  endtask

  task automatic test_backpressure();
    int idx, cyc, prev;
    pixelReady = 1'b0;
    pulse_start();
    cyc = 1; idx = 0; prev = 0;
    while (idx < NPIX && cyc < LIMIT) begin
      pixelReady = ($urandom_range(0, 99) >= 30);
      #1;
      if (busy) begin
        n_checks++;
        if (addr_pos(fbAddress) < prev) begin
          n_fail++;
          $display("FAIL bp_addr_order got pos %0d expected >= %0d", addr_pos(fbAddress), prev);
        end
        prev = addr_pos(fbAddress);
      end
      n_checks++; if (dut.count > 2) begin n_fail++; $display("FAIL bp_occupancy got %0d expected <= 2", dut.count); end
      if (pixelValid && pixelReady) begin
        n_checks++;
        if ({pixelLast, pixelLineEnd, pixelData} !== exp_pix(idx)) begin
          n_fail++;
          $display("FAIL bp_pixel idx %0d got %0h expected %0h", idx, {pixelLast, pixelLineEnd, pixelData}, exp_pix(idx));
        end
        idx++;
      end
      if (idx < NPIX) begin @(negedge clk); cyc++; end
    end
    n_checks++; if (idx !== NPIX) begin n_fail++; $display("FAIL bp_count got %0d expected %0d", idx, NPIX); end
    @(negedge clk);
    pixelReady = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || pixelValid !== 1'b0) begin n_fail++; $display("FAIL bp_end got busy %b valid %b expected 0 0", busy, pixelValid); end
  endtask

  task automatic test_stall();
    int idx, cyc;
    pixelReady = 1'b0;
    pulse_start();
    cyc = 1;
    #1;
    while (!pixelValid && cyc < 50) begin @(negedge clk); cyc++; #1; end
    n_checks++; if (pixelValid !== 1'b1) begin n_fail++; $display("FAIL stall_first_valid got %b expected 1", pixelValid); end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (pixelValid !== 1'b1 || {pixelLast, pixelLineEnd, pixelData} !== exp_pix(0)) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d got %b/%0h expected 1/%0h", k, pixelValid, pixelData, exp_pix(0));
      end
      n_checks++;
      if (fbAddress !== exp_addr(1)) begin
        n_fail++;
        $display("FAIL stall_reads cycle %0d got addr %0h expected %0h", k, fbAddress, exp_addr(1));
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
    pixelReady = 1'b1;
    cyc = 0; idx = 0;
    while (idx < NPIX && cyc < LIMIT) begin
      #1;
      if (pixelValid && pixelReady) begin
        n_checks++;
        if ({pixelLast, pixelLineEnd, pixelData} !== exp_pix(idx)) begin
          n_fail++;
          $display("FAIL stall_resume idx %0d got %0h expected %0h", idx, {pixelLast, pixelLineEnd, pixelData}, exp_pix(idx));
        end
        idx++;
      end
      if (idx < NPIX) begin @(negedge clk); cyc++; end
    end
    n_checks++; if (idx !== NPIX) begin n_fail++; $display("FAIL stall_count got %0d expected %0d", idx, NPIX); end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_drop got %b expected 0", busy); end
  endtask

  task automatic test_restart_ignored();
    int idx, cyc, pulsed, bad;
    pixelReady = 1'b1;
    pulse_start();
    cyc = 1; idx = 0; pulsed = 0;
    while (idx < NPIX && cyc < LIMIT) begin
      frameStart = (idx == 500 && pulsed == 0);
      if (frameStart) pulsed = 1;
      #1;
      if (pixelValid && pixelReady) begin
        n_checks++;
        if ({pixelLast, pixelLineEnd, pixelData} !== exp_pix(idx)) begin
          n_fail++;
          $display("FAIL restart_pixel idx %0d got %0h expected %0h", idx, {pixelLast, pixelLineEnd, pixelData}, exp_pix(idx));
        end
        idx++;
      end
      if (idx < NPIX) begin @(negedge clk); cyc++; end
    end
    frameStart = 1'b0;
    n_checks++; if (idx !== NPIX) begin n_fail++; $display("FAIL restart_count got %0d expected %0d", idx, NPIX); end
    bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (pixelValid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL restart_extra got %0d active cycles expected 0", bad); end
    pulse_start();
    cyc = 1; idx = 0;
    while (idx < NPIX && cyc < LIMIT) begin
      #1;
      if (pixelValid && pixelReady) begin
        n_checks++;
        if ({pixelLast, pixelLineEnd, pixelData} !== exp_pix(idx)) begin
          n_fail++;
          $display("FAIL second_frame idx %0d got %0h expected %0h", idx, {pixelLast, pixelLineEnd, pixelData}, exp_pix(idx));
        end
        idx++;
      end
      if (idx < NPIX) begin @(negedge clk); cyc++; end
    end
    n_checks++; if (idx !== NPIX) begin n_fail++; $display("FAIL second_count got %0d expected %0d", idx, NPIX); end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    int idx, cyc, bad;
    pixelReady = 1'b1;
    pulse_start();
    cyc = 1; idx = 0;
    while (idx < 1000 && cyc < LIMIT) begin
      #1;
      if (pixelValid && pixelReady) begin
        n_checks++;
        if ({pixelLast, pixelLineEnd, pixelData} !== exp_pix(idx)) begin
          n_fail++;
          $display("FAIL midrst_pixel idx %0d got %0h expected %0h", idx, {pixelLast, pixelLineEnd, pixelData}, exp_pix(idx));
        end
        idx++;
      end
      if (idx < 1000) begin @(negedge clk); cyc++; end
    end
    #1;
    n_checks++; if (pixelValid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got valid %b busy %b expected 1 1", pixelValid, busy); end
    resetN = 1'b0;
    #1;
    n_checks++; if (pixelValid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_async got %b expected 0", pixelValid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_async got %b expected 0", busy); end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (pixelValid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL midrst_quiet got %0d active cycles expected 0", bad); end
    pulse_start();
    cyc = 1; idx = 0;
    while (idx < NPIX && cyc < LIMIT) begin
      #1;
      if (pixelValid && pixelReady) begin
        n_checks++;
        if ({pixelLast, pixelLineEnd, pixelData} !== exp_pix(idx)) begin
          n_fail++;
          $display("FAIL midrst_restart idx %0d got %0h expected %0h", idx, {pixelLast, pixelLineEnd, pixelData}, exp_pix(idx));
        end
        idx++;
      end
      if (idx < NPIX) begin @(negedge clk); cyc++; end
    end
    n_checks++; if (idx !== NPIX) begin n_fail++; $display("FAIL midrst_count got %0d expected %0d", idx, NPIX); end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_drop got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_stall();
    test_restart_ignored();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Raster-order read engine on the framebuffer's second port (B). It streams one full frame of pixels to the downstream video/serializer stage over a valid/ready interface.
- A one-cycle frameStart pulse starts each frame.
- Absorbs the framebuffer's 1-cycle synchronous read latency with a 2-entry output buffer, so downstream backpressure never loses or duplicates a pixel.

Parameters:
- WIDTH, 9, pixel width in bits; equals framebuffer WIDTH.
- DEPTH, 2048, framebuffer word count; fbAddress width is $clog2(DEPTH).
- IMG_W, 64, pixels per row; IMG_W*IMG_H <= DEPTH (elaboration-time check, $error if violated).
- IMG_H, 32, rows per frame.

Ports:
- clk  input  1  single clock; also drives framebuffer clkB.
- resetN  input  1  asynchronous, active-low reset.
- frameStart  input  1  one-cycle start pulse; honoured only when busy=0.
- busy  output  1  high from the cycle after an accepted frameStart until the last pixel handshakes.
- fbAddress  output  $clog2(DEPTH)  to framebuffer addressB; writeEnableB tied 0 at top level.
- fbData  input  WIDTH  from framebuffer dataOutB; valid the cycle after the address is presented.
- pixelData  output  WIDTH  pixel value.
- pixelValid  output  1  pixelData/pixelLineEnd/pixelLast valid.
- pixelReady  input  1  downstream accepts when pixelValid&&pixelReady at posedge.
- pixelLineEnd  output  1  qualifies pixel at column IMG_W-1.
- pixelLast  output  1  qualifies final pixel of frame.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, pixelValid=0, pixelData=0, pixelLineEnd=0, pixelLast=0, fbAddress=0. Buffer, counters and pending flag are cleared. Reset mid-frame abandons the frame; no pixel appears after release until a new frameStart.
- FSM:
  - IDLE: frameStart -> ISSUE; row=col=0.
  - ISSUE: a read is issued in any cycle where (buffer occupancy + readPending) < 2. The issue cycle presents fbAddress = row*IMG_W+col and sets readPending for the next cycle. Then col increments; at IMG_W-1 it wraps to 0 and row increments. After the read for (IMG_H-1, IMG_W-1) is issued -> DRAIN.
  - DRAIN: no further reads. When the buffer is empty and no read is pending (last pixel handshaken) -> IDLE; busy drops in the same edge.
- Read return: when readPending, fbData is captured into the buffer tail. Tags lineEnd/last are computed at issue time and are delayed alongside the read.
- Buffer: 2-entry FIFO; the head drives the pixel* outputs.
  - pixelValid = not empty.
  - Pop on handshake. Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - The credit rule guarantees occupancy never exceeds 2, so no overflow path exists. The bench asserts it.
- Throughput: 1 pixel/cycle with pixelReady held high.
- Latency: frameStart at edge N -> first read at N+1 -> pixelValid at N+3.
- fbAddress holds its last value when not issuing. Extra reads are harmless because write enable is 0.
- frameStart while busy=1: ignored, no effect.
- pixelReady low: reads stall after 2 credits are used; pixelValid and head data stay stable until accepted.
- pixelLast implies pixelLineEnd.

Optional Feature:
- Macro SCANOUT_VFLIP_EN.
- Defined: the address row term uses (IMG_H-1-row), so the frame is emitted bottom row first. Columns are unchanged, and pixelLineEnd/pixelLast positions are unchanged in stream order.
- Undefined: normal top-to-bottom order as above; no extra logic.

Test Plan:
- Reset, memory[a]=a[8:0], IMG_W=64, IMG_H=32, pixelReady=1, one frameStart -> 2048 pixels, values 0..2047 mod 512 in order; pixelLineEnd on indices 63,127,...,2047; pixelLast only on index 2047; pixelValid first at frameStart+3 cycles; busy low 1 cycle after last handshake.
- Same frame, pixelReady toggled by a random 30%-low pattern -> identical 2048-value sequence, no drops or duplicates; fbAddress sequence monotonic; occupancy never exceeds 2.
- pixelReady=0 for 20 cycles after the first pixelValid -> at most 2 reads issued, pixelData stable at 0 throughout; resuming gives 1, 2, 3... contiguously.
- frameStart pulsed again at pixel index 500 -> ignored; frame completes normally; a second frameStart after busy=0 restarts at value 0.
- resetN asserted at pixel index 1000 -> pixelValid and busy go low immediately (asynchronously); after release no pixelValid until a new frameStart, then the stream starts at 0.
- SCANOUT_VFLIP_EN defined -> first pixel value 1984 (row 31), pixelLineEnd after value 2047, then 1920; pixelLast on value 63.
